// File: rtl/ws2812b_frame_feeder_if.sv
// Word handshake between the frame feeder (master) and the WS2812B serialiser (slave).
interface ws2812b_frame_feeder_if;
  logic        bitstream_available;
  logic [23:0] bitstream;
  logic        bitstream_read;

  modport master (
    output bitstream_available,
    output bitstream,
    input  bitstream_read
  );

  modport slave (
    input  bitstream_available,
    input  bitstream,
    output bitstream_read
  );
endinterface

// File: rtl/ws2812b_frame_feeder.sv
// Pixel memory plus frame walker: scales each RGB pixel by a frame-frozen brightness
// and presents it as a GRB word to the serialiser, then holds off for the latch period.
module ws2812b_frame_feeder #(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_WIDTH   = $clog2(NUM_LEDS),
  parameter int LATCH_CYCLES = 500,
  parameter int AUTO_REPEAT  = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [23:0]           wr_data,
  input  logic [7:0]            brightness,
  input  logic                  frame_start,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  protocol_err,
  ws2812b_frame_feeder_if.master bs
);

  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_LEDS - 1);
  localparam logic [ADDR_WIDTH:0]   NUM_EXT  = (ADDR_WIDTH + 1)'(NUM_LEDS);
  localparam logic [CNT_W-1:0]      LATCH_LD = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SCALE, PRESENT, LATCH} state_t;

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [8:0]  f;
    logic [15:0] p;
    f = {1'b0, b} + 9'd1;
    p = {8'd0, c} * {7'd0, f};
    return p[15:8];
  endfunction

  logic [23:0] mem [NUM_LEDS];

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] index, index_d;
  logic                  pending, pending_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [7:0]            bri_frame, bri_frame_d;
  logic                  done_d, perr_d;
  logic                  start_q, read_q;
  logic [23:0]           pix_p1;
  logic [23:0]           word_p2, word_d;
  logic                  vld_p2, vld_d;
  logic                  wr_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < NUM_EXT);

  // Host write port and FETCH read; nonblocking read gives read-first on a same-address write
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range)
      mem[wr_addr] <= wr_data;
    if (state == FETCH)
      pix_p1 <= mem[index];
  end

  // Both handshake inputs are registered, so every decision lands one cycle after sampling
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      start_q <= frame_start;
      read_q  <= bs.bitstream_read;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      index        <= '0;
      pending      <= 1'b0;
      cnt          <= '0;
      bri_frame    <= '0;
      word_p2      <= '0;
      vld_p2       <= 1'b0;
      frame_done   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_d;
      index        <= index_d;
      pending      <= pending_d;
      cnt          <= cnt_d;
      bri_frame    <= bri_frame_d;
      word_p2      <= word_d;
      vld_p2       <= vld_d;
      frame_done   <= done_d;
      protocol_err <= perr_d;
    end
  end

  always_comb begin
    state_d     = state;
    index_d     = index;
    pending_d   = pending;
    cnt_d       = cnt;
    bri_frame_d = bri_frame;
    word_d      = word_p2;
    vld_d       = vld_p2;
    done_d      = 1'b0;
    perr_d      = protocol_err | (read_q && (state != PRESENT));

    // Requests during a frame collapse into a single follow-on frame
    if (start_q && (state != IDLE))
      pending_d = 1'b1;

    case (state)
      IDLE: begin
        if (start_q || pending || (AUTO_REPEAT != 0)) begin
          index_d     = '0;
          bri_frame_d = brightness;
          pending_d   = 1'b0;
          state_d     = FETCH;
        end
      end
      FETCH: state_d = SCALE;
      SCALE: begin
        word_d  = {scale_ch(pix_p1[15:8],  bri_frame),
                   scale_ch(pix_p1[23:16], bri_frame),
                   scale_ch(pix_p1[7:0],   bri_frame)};
        vld_d   = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (read_q) begin
          vld_d = 1'b0;
          if (index == LAST_IDX) begin
            cnt_d   = LATCH_LD;
            state_d = LATCH;
          end else begin
            index_d = index + 1'b1;
            state_d = FETCH;
          end
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy                   = (state != IDLE);
  assign bs.bitstream_available = vld_p2;
  assign bs.bitstream           = word_p2;

endmodule

// File: tb/tb_ws2812b_frame_feeder.sv
// Directed bench for ws2812b_frame_feeder: latency, scaling, ordering, pending frames, reset abort.
module tb_ws2812b_frame_feeder;

  localparam int N     = 64;
  localparam int LATCH = 500;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [23:0] wr_data;
  logic [7:0]  brightness;
  logic        frame_start;
  logic        busy, frame_done, protocol_err;

  ws2812b_frame_feeder_if bs_if ();

  ws2812b_frame_feeder #(.NUM_LEDS(N), .LATCH_CYCLES(LATCH), .AUTO_REPEAT(0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .brightness   (brightness),
    .frame_start  (frame_start),
    .busy         (busy),
    .frame_done   (frame_done),
    .protocol_err (protocol_err),
    .bs           (bs_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int stab_err = 0;
  int last_busy = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [23:0] pat(input int i);
    logic [7:0] a;
    a = 8'(i);
    return {a, a ^ 8'hA5, 8'hFF - a};
  endfunction

  function automatic logic [23:0] grb(input logic [23:0] p);
    return {p[15:8], p[23:16], p[7:0]};
  endfunction

  task automatic wr_px(input int a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) wr_px(i, pat(i));
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Waits for a word, holds it for gap cycles, then pulses read; returns one cycle after the read edge
  task automatic serve(input int gap, output logic [23:0] w);
    int t;
    t = 0;
    w = '0;
    while (!bs_if.bitstream_available && t < 50) begin @(negedge clk); t++; end
    if (!bs_if.bitstream_available) begin
      check_eq("avail_timeout", 32'(bs_if.bitstream_available), 32'd1);
      return;
    end
    w = bs_if.bitstream;
    repeat (gap) begin
      @(negedge clk);
      if (!bs_if.bitstream_available || bs_if.bitstream !== w) stab_err++;
    end
    bs_if.bitstream_read = 1'b1;
    @(negedge clk);
    bs_if.bitstream_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    logic [23:0] w;
    for (int i = 0; i < n; i++) serve(1, w);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    last_busy = 0;
    while (!frame_done && k < LATCH + 200) begin
      last_busy = int'(busy);
      @(negedge clk);
      k++;
    end
    check_eq("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] w;
    int k, ord_err, got_n, t;

    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    brightness = 8'd255; frame_start = 1'b0; bs_if.bitstream_read = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(frame_done), 32'd0);
    check_eq("rst_perr",  32'(protocol_err), 32'd0);
    check_eq("rst_avail", 32'(bs_if.bitstream_available), 32'd0);
    check_eq("rst_word",  32'(bs_if.bitstream), 32'd0);

    // Basic frame with latency and latch timing
    fill_pattern();
    wr_px(0, 24'h112233);
    wr_px(1, 24'hAABBCC);
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    check_eq("start_lat_n2", 32'(bs_if.bitstream_available), 32'd0);
    @(negedge clk);
    check_eq("start_lat_n3", 32'(bs_if.bitstream_available), 32'd1);
    check_eq("word0",        32'(bs_if.bitstream), 32'h221133);
    check_eq("busy_frame",   32'(busy), 32'd1);
    bs_if.bitstream_read = 1'b1;
    @(negedge clk);
    bs_if.bitstream_read = 1'b0;
    check_eq("read_lat_m0", 32'(bs_if.bitstream_available), 32'd1);
    @(negedge clk);
    check_eq("read_lat_m1", 32'(bs_if.bitstream_available), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("read_lat_m3", 32'(bs_if.bitstream_available), 32'd1);
    check_eq("word1",       32'(bs_if.bitstream), 32'hBBAACC);
    serve(1, w);
    ord_err = 0;
    for (int i = 2; i < N; i++) begin
      serve(1, w);
      if (w !== grb(pat(i))) ord_err++;
    end
    check_eq("order_t1", 32'(ord_err), 32'd0);
    wait_done(k);
    // serve returns one cycle after the read edge, so LATCH more cycles make LATCH+1
    check_eq("done_delay", 32'(k), 32'(LATCH));
    check_eq("busy_before_done", 32'(last_busy), 32'd1);
    check_eq("busy_at_done", 32'(busy), 32'd0);

    // Brightness scaling and frame-frozen brightness
    wr_px(0, 24'hFF8040);
    wr_px(1, 24'h80FF40);
    brightness = 8'd127;
    pulse_start();
    serve(1, w);
    check_eq("bri127_px0", 32'(w), 32'h407F20);
    brightness = 8'd0;
    serve(1, w);
    check_eq("bri_frozen_px1", 32'(w), 32'h7F4020);
    drain(N - 2);
    wait_done(k);
    pulse_start();
    serve(1, w);
    check_eq("bri0_px0", 32'(w), 32'h000000);
    drain(N - 1);
    wait_done(k);

    // Full frame against a slow serialiser with random read spacing
    fill_pattern();
    brightness = 8'd255;
    stab_err = 0;
    ord_err = 0;
    got_n = 0;
    pulse_start();
    for (int i = 0; i < N; i++) begin
      serve(int'($urandom_range(200, 300)), w);
      got_n++;
      if (w !== grb(pat(i))) ord_err++;
    end
    wait_done(k);
    check_eq("slow_order",  32'(ord_err), 32'd0);
    check_eq("slow_count",  32'(got_n), 32'(N));
    check_eq("slow_stable", 32'(stab_err), 32'd0);
    check_eq("slow_perr",   32'(protocol_err), 32'd0);
    check_eq("slow_no_extra", 32'(bs_if.bitstream_available), 32'd0);

    // Two requests during a frame give exactly one more frame
    pulse_start();
    serve(1, w);
    pulse_start();
    @(negedge clk);
    pulse_start();
    drain(N - 1);
    wait_done(k);
    @(negedge clk);
    check_eq("pending_start", 32'(busy), 32'd1);
    drain(N);
    wait_done(k);
    repeat (20) @(negedge clk);
    check_eq("no_third_frame", 32'(busy), 32'd0);

    // Write collides with the FETCH read of index 5
    pulse_start();
    drain(5);
    wr_px(5, 24'h0A0B0C);
    serve(1, w);
    check_eq("px5_old", 32'(w), 32'(grb(pat(5))));
    drain(N - 6);
    wait_done(k);
    pulse_start();
    drain(5);
    serve(1, w);
    check_eq("px5_new", 32'(w), 32'h0B0A0C);
    drain(N - 6);
    wait_done(k);

    // Reset abort mid-PRESENT, then restart from index 0
    pulse_start();
    t = 0;
    while (!bs_if.bitstream_available && t < 20) begin @(negedge clk); t++; end
    check_eq("pre_rst_avail", 32'(bs_if.bitstream_available), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_async_avail", 32'(bs_if.bitstream_available), 32'd0);
    check_eq("rst_async_busy",  32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy",  32'(busy), 32'd0);
    check_eq("post_rst_avail", 32'(bs_if.bitstream_available), 32'd0);
    pulse_start();
    serve(1, w);
    check_eq("restart_idx0", 32'(w), 32'(grb(pat(0))));
    drain(N - 1);
    wait_done(k);

    // Spurious read while idle
    check_eq("perr_clear", 32'(protocol_err), 32'd0);
    bs_if.bitstream_read = 1'b1;
    @(negedge clk);
    bs_if.bitstream_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("perr_set", 32'(protocol_err), 32'd1);
    repeat (10) @(negedge clk);
    check_eq("perr_sticky", 32'(protocol_err), 32'd1);
    check_eq("perr_idle",   32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
